mem_burst_master: RTL
=====================

# mem_burst_master

Synthesizable initiator for the memory valid/ready protocol: the RTL counterpart that drives `wr_rd`/`addr`/`wdata`/`valid` into the memory responder and consumes `ready`/`rdata`. It accepts burst commands (start address plus length) on a command port and expands each one into sequential single-beat memory transfers. Write data streams in on a write-data port, and read data streams out on a read-data port with backpressure. It sits between a traffic source (DMA/test engine) and the memory design, replacing the testbench BFM on the initiator side.

## Interface
- `ADDR_WIDTH`, 8, memory address width (matches `` `ADDR_WIDTH``)
- `WIDTH`, 16, data width (matches `` `WIDTH``)
- `LEN_WIDTH`, 4, burst length field width; beats = `cmd_len`+1 (1..16)

Ports:
- `clk`  in  1  clock, all state on posedge
- `rst`  in  1  reset, asynchronous, active-high
- `cmd_valid`  in  1  command offered
- `cmd_ready`  out  1  command accepted when both high at posedge
- `cmd_wr`  in  1  1 = write burst, 0 = read burst
- `cmd_addr`  in  ADDR_WIDTH  first beat address
- `cmd_len`  in  LEN_WIDTH  beats minus one
- `wd_valid`  in  1  write data offered
- `wd_ready`  out  1  write data accepted when both high
- `wd_data`  in  WIDTH  write beat data
- `rd_valid`  out  1  read beat available
- `rd_ready`  in  1  read beat consumed when both high
- `rd_data`  out  WIDTH  read beat data
- `busy`  out  1  high in any state other than IDLE
- `done`  out  1  one-cycle pulse at burst completion
- `wr_rd`  out  1  memory op, 1 = write
- `addr`  out  ADDR_WIDTH  memory address
- `wdata`  out  WIDTH  memory write data
- `valid`  out  1  memory request
- `ready`  in  1  memory completion; `rdata` valid in the same cycle
- `rdata`  in  WIDTH  memory read data

## Operation
- States: IDLE, LOAD, ISSUE, RETURN, DONE.
- IDLE: `cmd_ready`=1. On `cmd_valid` it latches `cmd_wr`, `cmd_addr` and `cmd_len` into the beat counter. Next state is LOAD for a write, ISSUE for a read.
- LOAD (write only): `wd_ready`=1. On `wd_valid` it captures `wd_data` into the `wdata` register and moves to ISSUE. With no `wd_valid` it waits indefinitely with `valid`=0.
- ISSUE: `valid`=1. `wr_rd`, `addr` and `wdata` are held stable until the handshake. Handshake = `valid`&`ready` at posedge.
  - Write handshake: go to DONE if the counter is 0, else decrement, increment `addr`, and go to LOAD.
  - Read handshake: capture `rdata` into the `rd_data` register and go to RETURN.
- RETURN: `rd_valid`=1 and `rd_data` is stable. On `rd_ready`: go to DONE if the counter is 0, else decrement, increment `addr`, and go to ISSUE.
- DONE: `done`=1 for exactly one cycle, then IDLE. `cmd_ready`=0 in DONE.
- `addr` increments modulo 2^ADDR_WIDTH, so 0xFF wraps to 0x00 with no error.
- `ready` while `valid`=0 is ignored. `ready` held permanently high allows one beat per 2 cycles (LOAD/ISSUE or ISSUE/RETURN).
- `wd_valid` outside LOAD and `rd_ready` outside RETURN are ignored.
- `cmd_valid` outside IDLE is not accepted; the source holds it until `cmd_ready`.

## Timing
- All outputs are registered or decoded from the registered state; there are no combinational paths from inputs to outputs.
- Reset values: `cmd_ready`=0, `wd_ready`=0, `rd_valid`=0, `rd_data`=0, `busy`=0, `done`=0, `wr_rd`=0, `addr`=0, `wdata`=0, `valid`=0. While `rst` is high all outputs are 0, including `cmd_ready`.
- After `rst` falls, the state is IDLE and `cmd_ready`=1 from the first cycle.
- Reset mid-burst: `valid` drops asynchronously, the beat in flight is abandoned, no `done` pulse is produced, and the state returns to IDLE.
- Command accepted at edge N:
  - Read: `valid` is high in cycle N+1.
  - Write: `wd_ready` is high in cycle N+1, and `valid` is high the cycle after the `wd` handshake.
- Read handshake at edge M: `rd_valid` is high in cycle M+1.
- The last beat's handshake at edge K (memory `ready` for a write, `rd_ready` for a read) gives `done`=1 in cycle K+1 and `cmd_ready`=1 in cycle K+2.
- Minimum burst time is 2×beats+2 cycles from acceptance to `cmd_ready`.

## Test plan
- Single write: cmd wr=1, addr=0x10, len=0, wd_data=0xA5A5, ready tied high → one `valid` cycle with addr=0x10, wdata=0xA5A5, wr_rd=1; `done` pulses once; `busy` falls after `done`.
- Read burst with wrap: cmd wr=0, addr=0xFE, len=3, memory returns addr+0x100 → `addr` sequence 0xFE, 0xFF, 0x00, 0x01; `rd_data` sequence 0x01FE, 0x01FF, 0x0100, 0x0101; exactly 4 `rd_valid` handshakes.
- Memory stall: `ready` low for 5 cycles per beat on a 2-beat write → `valid`, `addr` and `wdata` stay constant throughout each stall; exactly 2 write handshakes.
- Backpressure: read len=1 with `rd_ready` low for 3 cycles → `rd_valid` and `rd_data` held; no second `valid` is issued until the first beat is consumed.
- Write starvation: write len=1 with `wd_valid` low for 4 cycles before beat 2 → `valid`=0 during the gap, `wd_ready`=1; the burst completes normally.
- Reset mid-burst: assert `rst` during ISSUE of beat 2 of 4 → `valid`=0 immediately and all outputs 0; after release `cmd_ready`=1, no `done` pulse occurs, and a new command runs correctly.

Source files
------------

// File: rtl/mem_burst_master.sv
// Burst initiator for the memory valid/ready protocol: expands {addr,len} commands
// into single-beat memory transfers, streaming write data in and read data out.
module mem_burst_master #(
  parameter int ADDR_WIDTH = 8,
  parameter int WIDTH      = 16,
  parameter int LEN_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  // command port
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_wr,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  // write-data port
  input  logic                  wd_valid,
  output logic                  wd_ready,
  input  logic [WIDTH-1:0]      wd_data,
  // read-data port
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [WIDTH-1:0]      rd_data,
  // status
  output logic                  busy,
  output logic                  done,
  output logic [2:0]            dbg_state,
  // memory side
  output logic                  wr_rd,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [WIDTH-1:0]      wdata,
  output logic                  valid,
  input  logic                  ready,
  input  logic [WIDTH-1:0]      rdata
);

  // Every port pair is a plain valid/ready handshake: a transfer happens on the
  // posedge where both are high; the producer holds payload stable until then.

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_ISSUE  = 3'd2,
    S_RETURN = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;
  localparam logic [LEN_WIDTH-1:0]  LEN_ONE  = 1;

  state_t                r_state;
  state_t                w_next;
  logic                  r_wr;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LEN_WIDTH-1:0]  r_cnt;
  logic [WIDTH-1:0]      r_wdata;
  logic [WIDTH-1:0]      r_rd_data;

  logic w_cmd_hs;
  logic w_wd_hs;
  logic w_mem_hs;
  logic w_rd_hs;
  logic w_last;
  logic w_advance;

  assign w_cmd_hs  = (r_state == S_IDLE) && cmd_valid;
  assign w_wd_hs   = (r_state == S_LOAD) && wd_valid;
  assign w_mem_hs  = (r_state == S_ISSUE) && ready;
  assign w_rd_hs   = (r_state == S_RETURN) && rd_ready;
  assign w_last    = (r_cnt == '0);
  // A beat retires on the memory handshake for writes, on the read-port handshake for reads.
  assign w_advance = ((w_mem_hs && r_wr) || w_rd_hs) && !w_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    cmd_ready = 1'b0;
    wd_ready  = 1'b0;
    valid     = 1'b0;
    rd_valid  = 1'b0;
    done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Gated by rst so every output reads 0 while reset is held.
        cmd_ready = !rst;
        if (cmd_valid) w_next = cmd_wr ? S_LOAD : S_ISSUE;
      end
      S_LOAD: begin
        wd_ready = 1'b1;
        if (wd_valid) w_next = S_ISSUE;
      end
      S_ISSUE: begin
        valid = 1'b1;
        if (ready) begin
          if (!r_wr)       w_next = S_RETURN;
          else if (w_last) w_next = S_DONE;
          else             w_next = S_LOAD;
        end
      end
      S_RETURN: begin
        rd_valid = 1'b1;
        if (rd_ready) w_next = w_last ? S_DONE : S_ISSUE;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr      <= 1'b0;
      r_addr    <= '0;
      r_cnt     <= '0;
      r_wdata   <= '0;
      r_rd_data <= '0;
    end else begin
      if (w_cmd_hs) begin
        r_wr   <= cmd_wr;
        r_addr <= cmd_addr;
        r_cnt  <= cmd_len;
      end
      if (w_wd_hs) r_wdata <= wd_data;
      if (w_mem_hs && !r_wr) r_rd_data <= rdata;
      // Address wraps modulo 2^ADDR_WIDTH by plain overflow.
      if (w_advance) begin
        r_cnt  <= r_cnt - LEN_ONE;
        r_addr <= r_addr + ADDR_ONE;
      end
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign dbg_state = r_state;
  assign wr_rd     = r_wr;
  assign addr      = r_addr;
  assign wdata     = r_wdata;
  assign rd_data   = r_rd_data;

endmodule
